// File: rtl/lift_row_ctrl.sv
// Row sequencer for the 5/3 lifting predict step: streams a row out of a sync-read line
// buffer, issues (s[i-1], s[i], s[i+1]) triples for odd i and writes each detail back in place.
module lift_row_ctrl #(
  parameter int DW     = 10,
  parameter int AW     = 9,
  parameter int DP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   row_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] dp_x2,
  output logic [DW-1:0] dp_x3,
  output logic [DW-1:0] dp_x4,
  output logic          dp_vld,
  input  logic [DW-1:0] dp_d,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  state_t        r_state;
  logic          r_busy, r_done, r_err;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_lm1;
  logic [AW-1:0] r_last;

  logic          r_rv;
  logic [AW-1:0] r_ra;
  logic [DW-1:0] r_even;

  logic          r_vld;
  logic          r_ext;
  logic [DW-1:0] r_x2, r_x3, r_x4_hold;
  logic [AW-1:0] r_iaddr;

  logic [DP_LAT-1:0] r_wr_vld_p;
  logic [AW-1:0]     r_wr_addr_p [DP_LAT];

  logic          w_len_ok;
  logic [AW-1:0] w_lm1;
  logic [AW-1:0] w_last;
  logic [DW-1:0] w_x4;

  assign w_len_ok = (row_len >= (AW+1)'(2)) && (row_len <= MAX_LEN);
  assign w_lm1    = row_len[AW-1:0] - AW'(1);
  assign w_last   = w_lm1[0] ? w_lm1 : (w_lm1 - AW'(1));

  // The right neighbour lands on rd_data in the issue cycle itself, so it is forwarded
  // combinationally; at the end of an even-length row it mirrors the left neighbour.
  assign w_x4 = r_vld ? (r_ext ? r_x2 : rd_data) : r_x4_hold;

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign dp_x2   = r_x2;
  assign dp_x3   = r_x3;
  assign dp_x4   = w_x4;
  assign dp_vld  = r_vld;
  assign wr_en   = r_wr_vld_p[DP_LAT-1];
  assign wr_addr = r_wr_addr_p[DP_LAT-1];
  assign wr_data = r_wr_vld_p[DP_LAT-1] ? dp_d : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_lm1      <= '0;
      r_last     <= '0;
      r_rv       <= 1'b0;
      r_ra       <= '0;
      r_even     <= '0;
      r_vld      <= 1'b0;
      r_ext      <= 1'b0;
      r_x2       <= '0;
      r_x3       <= '0;
      r_x4_hold  <= '0;
      r_iaddr    <= '0;
      r_wr_vld_p <= '0;
      for (int j = 0; j < DP_LAT; j++) r_wr_addr_p[j] <= '0;
    end else begin
      // read return: rd_data carries s[r_ra] while r_rv is set
      r_rv <= r_rd_en;
      r_ra <= r_rd_addr;

      // issue: odd sample arriving now completes a triple (x4 follows next cycle)
      r_vld <= 1'b0;
      if (r_vld) r_x4_hold <= w_x4;
      if (r_rv) begin
        if (!r_ra[0]) begin
          r_even <= rd_data;
        end else begin
          r_vld   <= 1'b1;
          r_x2    <= r_even;
          r_x3    <= rd_data;
          r_ext   <= (r_ra == r_lm1);
          r_iaddr <= r_ra;
        end
      end

      // write-back: valid and address ride alongside the datapath latency
      r_wr_vld_p[0]  <= r_vld;
      r_wr_addr_p[0] <= r_iaddr;
      for (int j = 1; j < DP_LAT; j++) begin
        r_wr_vld_p[j]  <= r_wr_vld_p[j-1];
        r_wr_addr_p[j] <= r_wr_addr_p[j-1];
      end

      // sequencing
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_state   <= S_STREAM;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_lm1     <= w_lm1;
              r_last    <= w_last;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (r_rd_addr == r_lm1) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_wr_vld_p[DP_LAT-1] && (r_wr_addr_p[DP_LAT-1] == r_last)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_row_ctrl.sv
// Directed bench for lift_row_ctrl: two instances (datapath latency 1 and 3), each with a
// sync-read line buffer and a registered predict stub d = x3 - ((x2+x4)>>1).
module tb_lift_row_ctrl;
  localparam int DW = 10;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s0_start = 1'b0, s1_start = 1'b0;
  logic [AW:0]   s0_len = '0, s1_len = '0;
  logic          o0_busy, o0_done, o0_err, o0_rd_en, o0_vld, o0_wr_en;
  logic          o1_busy, o1_done, o1_err, o1_rd_en, o1_vld, o1_wr_en;
  logic [AW-1:0] o0_rd_addr, o0_wr_addr, o1_rd_addr, o1_wr_addr;
  logic [DW-1:0] o0_x2, o0_x3, o0_x4, o0_wr_data, o1_x2, o1_x3, o1_x4, o1_wr_data;
  logic [DW-1:0] s0_rd_data = '0, s1_rd_data = '0, s0_d = '0, s1_d = '0;
  logic [DW-1:0] s1_p1 = '0, s1_p2 = '0;

  lift_row_ctrl #(.DW(DW), .AW(AW), .DP_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(s0_start), .row_len(s0_len),
    .busy(o0_busy), .done(o0_done), .err(o0_err),
    .rd_en(o0_rd_en), .rd_addr(o0_rd_addr), .rd_data(s0_rd_data),
    .dp_x2(o0_x2), .dp_x3(o0_x3), .dp_x4(o0_x4), .dp_vld(o0_vld), .dp_d(s0_d),
    .wr_en(o0_wr_en), .wr_addr(o0_wr_addr), .wr_data(o0_wr_data));

  lift_row_ctrl #(.DW(DW), .AW(AW), .DP_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .row_len(s1_len),
    .busy(o1_busy), .done(o1_done), .err(o1_err),
    .rd_en(o1_rd_en), .rd_addr(o1_rd_addr), .rd_data(s1_rd_data),
    .dp_x2(o1_x2), .dp_x3(o1_x3), .dp_x4(o1_x4), .dp_vld(o1_vld), .dp_d(s1_d),
    .wr_en(o1_wr_en), .wr_addr(o1_wr_addr), .wr_data(o1_wr_data));

  logic [DW-1:0] ram0 [512];
  logic [DW-1:0] ram1 [512];
  logic [DW-1:0] init_v [16];
  logic          load0 = 1'b0, load1 = 1'b0;

  always @(posedge clk) begin
    if (load0) for (int i = 0; i < 16; i++) ram0[i] <= init_v[i];
    else if (o0_wr_en) ram0[o0_wr_addr] <= o0_wr_data;
    if (o0_rd_en) s0_rd_data <= ram0[o0_rd_addr];
    s0_d <= o0_x3 - DW'(({1'b0, o0_x2} + {1'b0, o0_x4}) >> 1);
  end

  always @(posedge clk) begin
    if (load1) for (int i = 0; i < 16; i++) ram1[i] <= init_v[i];
    else if (o1_wr_en) ram1[o1_wr_addr] <= o1_wr_data;
    if (o1_rd_en) s1_rd_data <= ram1[o1_rd_addr];
    s1_p1 <= o1_x3 - DW'(({1'b0, o1_x2} + {1'b0, o1_x4}) >> 1);
    s1_p2 <= s1_p1;
    s1_d  <= s1_p2;
  end

  int tests = 0;
  int fails = 0;

  // Per-cycle record of one row, cycle k = k-th cycle after the start-accepting edge.
  logic [63:0]   m_rd, m_vld, m_wr, m_done, m_busy, m_err;
  logic [AW-1:0] a_ra [64];
  logic [AW-1:0] a_wa [64];
  logic [DW-1:0] a_wd [64];
  logic [DW-1:0] a_x2 [64];
  logic [DW-1:0] a_x3 [64];
  logic [DW-1:0] a_x4 [64];

  task automatic load_ram(input int sel, input int n, input int v0, input int v1, input int v2,
                          input int v3, input int v4, input int v5, input int v6, input int v7);
    int vals [8];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 16; i++) init_v[i] = (i < n && i < 8) ? DW'(vals[i]) : '0;
    @(posedge clk); #1;
    if (sel == 0) load0 = 1'b1; else load1 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic run_row(input int sel, input int len, input int ncyc, input int spam_until,
                         input int restart_at);
    logic st;
    m_rd = '0; m_vld = '0; m_wr = '0; m_done = '0; m_busy = '0; m_err = '0;
    @(posedge clk); #1;
    if (sel == 0) begin s0_start = 1'b1; s0_len = (AW+1)'(len); end
    else begin s1_start = 1'b1; s1_len = (AW+1)'(len); end
    @(posedge clk); #1;
    for (int k = 1; k <= ncyc; k++) begin
      st = (k <= spam_until) || (k == restart_at);
      if (sel == 0) begin
        s0_start = st;
        m_rd[k] = o0_rd_en; m_vld[k] = o0_vld; m_wr[k] = o0_wr_en;
        m_done[k] = o0_done; m_busy[k] = o0_busy; m_err[k] = o0_err;
        a_ra[k] = o0_rd_addr; a_wa[k] = o0_wr_addr; a_wd[k] = o0_wr_data;
        a_x2[k] = o0_x2; a_x3[k] = o0_x3; a_x4[k] = o0_x4;
      end else begin
        s1_start = st;
        m_rd[k] = o1_rd_en; m_vld[k] = o1_vld; m_wr[k] = o1_wr_en;
        m_done[k] = o1_done; m_busy[k] = o1_busy; m_err[k] = o1_err;
        a_ra[k] = o1_rd_addr; a_wa[k] = o1_wr_addr; a_wd[k] = o1_wr_data;
        a_x2[k] = o1_x2; a_x3[k] = o1_x3; a_x4[k] = o1_x4;
      end
      @(posedge clk); #1;
    end
    s0_start = 1'b0;
    s1_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o0_busy, o0_done, o0_err, o0_rd_en, o0_vld, o0_wr_en, o1_busy, o1_done, o1_err, o1_rd_en, o1_vld, o1_wr_en} !== 12'h000) begin
      fails++; $display("FAIL reset_ctl got %b exp 0", {o0_busy, o0_done, o0_err, o0_rd_en, o0_vld, o0_wr_en, o1_busy, o1_done, o1_err, o1_rd_en, o1_vld, o1_wr_en});
    end
    tests++;
    if ({o0_rd_addr, o0_wr_addr, o0_x2, o0_x3, o0_x4, o0_wr_data} !== '0) begin
      fails++; $display("FAIL reset_data got %h exp 0", {o0_rd_addr, o0_wr_addr, o0_x2, o0_x3, o0_x4, o0_wr_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_len4();
    load_ram(0, 4, 100, 120, 140, 90, 0, 0, 0, 0);
    run_row(0, 4, 12, 0, 0);
    tests++; if (m_rd !== 64'h1E) begin fails++; $display("FAIL len4_rd_mask got %h exp %h", m_rd, 64'h1E); end
    for (int k = 1; k <= 4; k++) begin
      tests++; if (a_ra[k] !== AW'(k-1)) begin fails++; $display("FAIL len4_rd_addr c%0d got %0d exp %0d", k, a_ra[k], k-1); end
    end
    tests++; if (m_vld !== 64'h50) begin fails++; $display("FAIL len4_vld_mask got %h exp %h", m_vld, 64'h50); end
    tests++; if ({a_x2[4], a_x3[4], a_x4[4]} !== {10'd100, 10'd120, 10'd140}) begin fails++; $display("FAIL len4_issue1 got %0d,%0d,%0d exp 100,120,140", a_x2[4], a_x3[4], a_x4[4]); end
    tests++; if ({a_x2[6], a_x3[6], a_x4[6]} !== {10'd140, 10'd90, 10'd140}) begin fails++; $display("FAIL len4_issue2_ext got %0d,%0d,%0d exp 140,90,140", a_x2[6], a_x3[6], a_x4[6]); end
    tests++; if (m_wr !== 64'hA0) begin fails++; $display("FAIL len4_wr_mask got %h exp %h", m_wr, 64'hA0); end
    tests++; if ({a_wa[5], a_wd[5]} !== {9'd1, 10'h000}) begin fails++; $display("FAIL len4_wr1 got a%0d d%h exp a1 d000", a_wa[5], a_wd[5]); end
    tests++; if ({a_wa[7], a_wd[7]} !== {9'd3, 10'h3CE}) begin fails++; $display("FAIL len4_wr2 got a%0d d%h exp a3 d3ce", a_wa[7], a_wd[7]); end
    tests++; if (m_done !== 64'h100) begin fails++; $display("FAIL len4_done got %h exp %h", m_done, 64'h100); end
    tests++; if (m_busy !== 64'h1FE) begin fails++; $display("FAIL len4_busy got %h exp %h", m_busy, 64'h1FE); end
    tests++; if (m_err !== 64'h0) begin fails++; $display("FAIL len4_err got %h exp 0", m_err); end
    tests++; if ({ram0[0], ram0[1], ram0[2], ram0[3]} !== {10'd100, 10'h000, 10'd140, 10'h3CE}) begin fails++; $display("FAIL len4_ram got %h %h %h %h exp 064 000 08c 3ce", ram0[0], ram0[1], ram0[2], ram0[3]); end
  endtask

  task automatic test_len5_odd();
    load_ram(0, 5, 10, 20, 30, 40, 50, 0, 0, 0);
    run_row(0, 5, 12, 0, 0);
    tests++; if (m_rd !== 64'h3E) begin fails++; $display("FAIL len5_rd_mask got %h exp %h", m_rd, 64'h3E); end
    for (int k = 1; k <= 5; k++) begin
      tests++; if (a_ra[k] !== AW'(k-1)) begin fails++; $display("FAIL len5_rd_addr c%0d got %0d exp %0d", k, a_ra[k], k-1); end
    end
    tests++; if (m_vld !== 64'h50) begin fails++; $display("FAIL len5_vld_mask got %h exp %h", m_vld, 64'h50); end
    tests++; if (a_x4[6] !== 10'd50) begin fails++; $display("FAIL len5_x4_noext got %0d exp 50", a_x4[6]); end
    tests++; if (m_wr !== 64'hA0) begin fails++; $display("FAIL len5_wr_mask got %h exp %h", m_wr, 64'hA0); end
    tests++; if ({a_wa[5], a_wd[5], a_wa[7], a_wd[7]} !== {9'd1, 10'd0, 9'd3, 10'd0}) begin fails++; $display("FAIL len5_wr got a%0d d%h a%0d d%h exp a1 d0 a3 d0", a_wa[5], a_wd[5], a_wa[7], a_wd[7]); end
    tests++; if (m_done !== 64'h100) begin fails++; $display("FAIL len5_done got %h exp %h", m_done, 64'h100); end
    tests++; if ({ram0[1], ram0[2], ram0[3], ram0[4]} !== {10'd0, 10'd30, 10'd0, 10'd50}) begin fails++; $display("FAIL len5_ram got %0d %0d %0d %0d exp 0 30 0 50", ram0[1], ram0[2], ram0[3], ram0[4]); end
  endtask

  task automatic test_len8();
    load_ram(0, 8, 164, 164, 164, 156, 108, 200, 254, 0);
    run_row(0, 8, 16, 0, 0);
    tests++; if (m_rd !== 64'h1FE) begin fails++; $display("FAIL len8_rd_mask got %h exp %h", m_rd, 64'h1FE); end
    tests++; if (m_vld !== 64'h550) begin fails++; $display("FAIL len8_vld_mask got %h exp %h", m_vld, 64'h550); end
    tests++; if (m_wr !== 64'hAA0) begin fails++; $display("FAIL len8_wr_mask got %h exp %h", m_wr, 64'hAA0); end
    tests++; if ({a_wa[5], a_wa[7], a_wa[9], a_wa[11]} !== {9'd1, 9'd3, 9'd5, 9'd7}) begin fails++; $display("FAIL len8_wr_addr got %0d %0d %0d %0d exp 1 3 5 7", a_wa[5], a_wa[7], a_wa[9], a_wa[11]); end
    tests++; if ({a_wd[5], a_wd[7], a_wd[9], a_wd[11]} !== {10'h000, 10'h014, 10'h013, 10'h302}) begin fails++; $display("FAIL len8_wr_data got %h %h %h %h exp 000 014 013 302", a_wd[5], a_wd[7], a_wd[9], a_wd[11]); end
    tests++; if (m_done !== 64'h1000) begin fails++; $display("FAIL len8_done got %h exp %h", m_done, 64'h1000); end
    tests++; if (m_busy !== 64'h1FFE) begin fails++; $display("FAIL len8_busy got %h exp %h", m_busy, 64'h1FFE); end
  endtask

  task automatic test_illegal_len();
    int lens [3];
    lens = '{1, 513, 0};
    for (int t = 0; t < 3; t++) begin
      run_row(0, lens[t], 6, 0, 0);
      tests++; if ({m_done, m_err} !== {64'h2, 64'h2}) begin fails++; $display("FAIL illegal_done_err len%0d got %h/%h exp 2/2", lens[t], m_done, m_err); end
      tests++; if ({m_busy, m_rd, m_wr, m_vld} !== '0) begin fails++; $display("FAIL illegal_quiet len%0d got b%h r%h w%h v%h exp 0", lens[t], m_busy, m_rd, m_wr, m_vld); end
    end
  endtask

  task automatic test_start_ignored();
    load_ram(0, 8, 164, 164, 164, 156, 108, 200, 254, 0);
    run_row(0, 8, 16, 12, 0);
    tests++; if (m_rd !== 64'h1FE) begin fails++; $display("FAIL spam_rd_mask got %h exp %h", m_rd, 64'h1FE); end
    tests++; if (m_wr !== 64'hAA0) begin fails++; $display("FAIL spam_wr_mask got %h exp %h", m_wr, 64'hAA0); end
    tests++; if ({m_done, m_busy} !== {64'h1000, 64'h1FFE}) begin fails++; $display("FAIL spam_done_busy got %h/%h exp 1000/1ffe", m_done, m_busy); end
    tests++; if (a_wd[11] !== 10'h302) begin fails++; $display("FAIL spam_wr_last got %h exp 302", a_wd[11]); end
  endtask

  task automatic test_lat3();
    load_ram(1, 8, 164, 164, 164, 156, 108, 200, 254, 0);
    run_row(1, 8, 18, 0, 0);
    tests++; if (m_rd !== 64'h1FE) begin fails++; $display("FAIL lat3_rd_mask got %h exp %h", m_rd, 64'h1FE); end
    tests++; if (m_vld !== 64'h550) begin fails++; $display("FAIL lat3_vld_mask got %h exp %h", m_vld, 64'h550); end
    tests++; if (m_wr !== 64'h2A80) begin fails++; $display("FAIL lat3_wr_mask got %h exp %h", m_wr, 64'h2A80); end
    tests++; if ({a_wa[7], a_wa[9], a_wa[11], a_wa[13]} !== {9'd1, 9'd3, 9'd5, 9'd7}) begin fails++; $display("FAIL lat3_wr_addr got %0d %0d %0d %0d exp 1 3 5 7", a_wa[7], a_wa[9], a_wa[11], a_wa[13]); end
    tests++; if ({a_wd[7], a_wd[9], a_wd[11], a_wd[13]} !== {10'h000, 10'h014, 10'h013, 10'h302}) begin fails++; $display("FAIL lat3_wr_data got %h %h %h %h exp 000 014 013 302", a_wd[7], a_wd[9], a_wd[11], a_wd[13]); end
    tests++; if ({m_done, m_busy} !== {64'h4000, 64'h7FFE}) begin fails++; $display("FAIL lat3_done_busy got %h/%h exp 4000/7ffe", m_done, m_busy); end
    tests++; if (ram1[7] !== 10'h302) begin fails++; $display("FAIL lat3_ram7 got %h exp 302", ram1[7]); end
  endtask

  task automatic test_back_to_back();
    load_ram(0, 2, 7, 30, 0, 0, 0, 0, 0, 0);
    run_row(0, 2, 10, 0, 7);
    tests++; if (m_rd !== 64'h306) begin fails++; $display("FAIL b2b_rd_mask got %h exp %h", m_rd, 64'h306); end
    tests++; if ({m_vld, m_wr} !== {64'h10, 64'h20}) begin fails++; $display("FAIL b2b_vld_wr got %h/%h exp 10/20", m_vld, m_wr); end
    tests++; if ({a_wa[5], a_wd[5]} !== {9'd1, 10'd23}) begin fails++; $display("FAIL b2b_len2_write got a%0d d%0d exp a1 d23", a_wa[5], a_wd[5]); end
    tests++; if ({m_done, m_busy} !== {64'h40, 64'h77E}) begin fails++; $display("FAIL b2b_done_busy got %h/%h exp 40/77e", m_done, m_busy); end
    repeat (12) @(posedge clk);
    #1;
    tests++; if (o0_busy !== 1'b0) begin fails++; $display("FAIL b2b_second_row_end got busy %b exp 0", o0_busy); end
  endtask

  task automatic test_reset_mid_row();
    logic seen;
    load_ram(0, 8, 164, 164, 164, 156, 108, 200, 254, 0);
    @(posedge clk); #1;
    s0_start = 1'b1; s0_len = (AW+1)'(8);
    @(posedge clk); #1;
    s0_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests++;
    if ({o0_busy, o0_done, o0_err, o0_rd_en, o0_vld, o0_wr_en, o0_rd_addr, o0_wr_addr, o0_x2, o0_x3, o0_x4, o0_wr_data} !== '0) begin
      fails++; $display("FAIL midrst_outputs got %h exp 0", {o0_busy, o0_done, o0_err, o0_rd_en, o0_vld, o0_wr_en, o0_rd_addr, o0_wr_addr, o0_x2, o0_x3, o0_x4, o0_wr_data});
    end
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      seen = seen | o0_wr_en | o0_done | o0_busy | o0_rd_en;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_activity got %b exp 0", seen); end
    tests++; if ({ram0[1], ram0[3]} !== {10'd0, 10'd156}) begin fails++; $display("FAIL midrst_ram got %0d %0d exp 0 156", ram0[1], ram0[3]); end
    load_ram(0, 4, 100, 120, 140, 90, 0, 0, 0, 0);
    run_row(0, 4, 12, 0, 0);
    tests++; if ({m_rd, m_wr, m_done} !== {64'h1E, 64'hA0, 64'h100}) begin fails++; $display("FAIL midrst_rerun_masks got %h/%h/%h exp 1e/a0/100", m_rd, m_wr, m_done); end
    tests++; if (a_wd[7] !== 10'h3CE) begin fails++; $display("FAIL midrst_rerun_data got %h exp 3ce", a_wd[7]); end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_len5_odd();
    test_len8();
    test_illegal_len();
    test_start_ignored();
    test_lat3();
    test_back_to_back();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
